obi_data_mem_responder: RTL and testbench
=========================================

Name: obi_data_mem_responder

Overview:
- Memory-side responder for the core's data bus (OBI-style req/gnt/rvalid). Sits downstream of the core's load/store unit in simulation top-levels, in place of hand-driven data_gnt/data_rvalid stimulus.
- Backs a small word-addressed RAM. Returns in-order responses after a configurable latency.
- By construction it never issues a grant without a request and never issues an rvalid without an outstanding granted transaction.

Parameters:
AddrBase, 32'h0000_0000, byte base address of the RAM window
MemWords, 256, RAM depth in 32-bit words; power of 2, minimum 4
MaxOutstanding, 2, response FIFO depth; maximum number of granted transactions without a response
RespLatency, 1, minimum cycles from grant to rvalid; must be >= 1

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
data_req_i  in  1  core request
data_gnt_o  out  1  grant; combinational
data_we_i  in  1  1 = write, 0 = read
data_be_i  in  4  byte enables
data_addr_i  in  32  byte address
data_wdata_i  in  32  write data
data_rvalid_o  out  1  response valid; registered
data_rdata_o  out  32  read data; registered
data_err_o  out  1  response error; registered
gnt_stall_i  in  1  bench backpressure injection; 1 suppresses grant
outstanding_o  out  $clog2(MaxOutstanding+1)  granted transactions still awaiting rvalid

Behaviour:
- Reset (rst_ni low, async):
  - data_gnt_o, data_rvalid_o, data_err_o = 0; data_rdata_o = 0; outstanding_o = 0.
  - FIFO is flushed; all RAM words = 0.
  - Reset mid-operation discards every pending response. No rvalid is issued after release for pre-reset grants.
- Grant:
  - data_gnt_o = rst_ni & data_req_i & ~gnt_stall_i & (outstanding_o < MaxOutstanding).
  - A handshake occurs on a rising edge when req & gnt are both high.
  - Capacity is judged on the current count. A response leaving in the same cycle does not free a slot.
- Decode, evaluated at the handshake edge:
  - err = (addr < AddrBase) | (addr >= AddrBase + 4*MemWords) | (addr[1:0] != 0).
  - Word index = (addr - AddrBase) >> 2.
- Write handshake without err: RAM bytes i with be[i]=1 are updated from wdata[8i+7:8i] at that edge. The response carries rdata = 0.
- Read handshake without err:
  - rdata is the RAM word value before the edge.
  - A write to the same word in a prior cycle is visible.
  - be is ignored; the full word is returned.
- Any errored transaction leaves the RAM unmodified and responds with rdata = 0, err = 1.
- FIFO and response timing:
  - Each handshake pushes {err, rdata, age counter}.
  - The response for a handshake at edge T drives data_rvalid_o high in cycle T + RespLatency at the earliest.
  - Responses are strictly in order and at most one rvalid per cycle. The actual cycle is max(T + RespLatency, previous rvalid cycle + 1).
  - data_rvalid_o is high for exactly one cycle per transaction. data_rdata_o and data_err_o are valid only when rvalid is high and are 0 otherwise.
- outstanding_o:
  - Increments on a handshake and decrements in the rvalid cycle.
  - A handshake and an rvalid in the same cycle leave it unchanged.
  - It never exceeds MaxOutstanding and never underflows.
- gnt_stall_i and data_req_i changes never affect already-granted transactions.
- data_req_i is not required to stay high until granted (responder is tolerant). Attributes are sampled only at handshake edges.
- Simulation assertions (disabled in reset):
  - gnt implies req.
  - rvalid implies outstanding_o > 0.
  - FIFO never overflows.
  - Each parameter satisfies its stated constraint.

Test Plan:
- Single read after reset, RespLatency=1: read addr 0x0 with req=1 at cycle 0 -> gnt=1 in cycle 0; rvalid=1, rdata=0x0, err=0 in cycle 1; outstanding_o goes 0→1→0.
- Byte-enable write then read:
  - Write addr 0x10, wdata 0xAABBCCDD, be=4'b0101 -> write response rvalid with rdata=0, err=0.
  - Then read 0x10 -> rdata 0x00BB00DD.
- Back-to-back with MaxOutstanding=2, RespLatency=3:
  - req held high for 4 reads -> gnt high for 2 cycles, then low until the first rvalid.
  - Responses arrive in order, one per cycle, first at grant edge + 3.
- Error cases:
  - Read addr AddrBase + 4*MemWords (0x400) -> rvalid, err=1, rdata=0.
  - Write 0x402 -> err=1, and RAM word 0 is unchanged on readback.
- No unsolicited handshakes:
  - req=0 for 20 cycles with random gnt_stall_i -> gnt and rvalid stay 0 throughout.
  - gnt_stall_i=1 with req=1 -> gnt=0 and no rvalid.
- Reset mid-flight: grant 2 reads with RespLatency=3, then assert rst_ni low 1 cycle after the second grant -> no rvalid after release, outstanding_o=0, and previously written words read back 0.

Source files
------------

// File: rtl/obi_data_mem_responder.sv
// OBI data-bus RAM responder: in-order responses RespLatency+ cycles after grant, registered rvalid.
// Grant withheld while MaxOutstanding responses are pending or gnt_stall_i is high; no rready.

module obi_resp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_vld,
  input  logic [Width-1:0] in_dat,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [Width-1:0] out_dat,
  input  logic             out_rdy
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_rdy  = (r_cnt != CntW'(Depth));
  assign out_vld = (r_cnt != '0);
  assign out_dat = r_mem[r_rd_ptr];
  assign w_push  = in_vld & in_rdy;
  assign w_pop   = out_vld & out_rdy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_dat;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
    end
  end
endmodule

module obi_data_mem_responder #(
  parameter logic [31:0] AddrBase       = 32'h0000_0000,
  parameter int unsigned MemWords       = 256,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned RespLatency    = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                data_req_i,
  output logic                                data_gnt_o,
  input  logic                                data_we_i,
  input  logic [3:0]                          data_be_i,
  input  logic [31:0]                         data_addr_i,
  input  logic [31:0]                         data_wdata_i,
  output logic                                data_rvalid_o,
  output logic [31:0]                         data_rdata_o,
  output logic                                data_err_o,
  input  logic                                gnt_stall_i,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o
);
  localparam int unsigned IdxW = $clog2(MemWords);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  // Wide enough that a waiting entry's age cannot wrap before it is popped.
  localparam int unsigned TsW  = $clog2(RespLatency + MaxOutstanding + 2) + 1;
  localparam int unsigned EntW = 1 + 32 + TsW;
  localparam logic [32:0] WinEnd = {1'b0, AddrBase} + 33'(MemWords) * 33'd4;

  typedef struct packed {
    logic           err;
    logic [31:0]    rdata;
    logic [TsW-1:0] ts;
  } resp_t;

  logic [31:0]     r_mem [MemWords];
  logic [TsW-1:0]  r_now;
  logic [CntW-1:0] r_outstanding;
  logic            r_rvalid;
  logic            r_err;
  logic [31:0]     r_rdata;

  logic            w_gnt;
  logic            w_hs;
  logic            w_err;
  logic [31:0]     w_off;
  logic [IdxW-1:0] w_idx;
  logic            w_fifo_in_rdy;
  logic            w_fifo_vld;
  logic [TsW-1:0]  w_head_age;
  logic            w_head_rdy;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic            w_resp_vld;
  resp_t           w_in;
  resp_t           w_head;
  resp_t           w_resp;

  assign w_gnt = rst_ni & data_req_i & ~gnt_stall_i & (r_outstanding < CntW'(MaxOutstanding));
  assign w_hs  = data_req_i & w_gnt;
  assign w_off = data_addr_i - AddrBase;
  assign w_idx = IdxW'(w_off >> 2);
  assign w_err = (data_addr_i < AddrBase) | ({1'b0, data_addr_i} >= WinEnd) |
                 (data_addr_i[1:0] != 2'b00);

  always_comb begin
    w_in.err   = w_err;
    w_in.rdata = (w_err | data_we_i) ? 32'h0 : r_mem[w_idx];
    w_in.ts    = r_now;
  end

  obi_resp_fifo #(.Width(EntW), .Depth(MaxOutstanding)) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .in_vld  (w_push),
    .in_dat  (w_in),
    .in_rdy  (w_fifo_in_rdy),
    .out_vld (w_fifo_vld),
    .out_dat (w_head),
    .out_rdy (w_head_rdy)
  );

  // rvalid is registered, so a response is launched one edge before its cycle.
  assign w_head_age = r_now - w_head.ts;
  assign w_head_rdy = (w_head_age >= TsW'(RespLatency - 1));
  assign w_bypass   = w_hs & ~w_fifo_vld & (RespLatency == 1);
  assign w_push     = w_hs & ~w_bypass;
  assign w_pop      = w_fifo_vld & w_head_rdy;
  assign w_resp_vld = w_pop | w_bypass;
  assign w_resp     = w_fifo_vld ? w_head : w_in;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_now         <= '0;
      r_rvalid      <= 1'b0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_outstanding <= '0;
    end else begin
      r_now         <= r_now + 1'b1;
      r_rvalid      <= w_resp_vld;
      r_rdata       <= w_resp_vld ? w_resp.rdata : 32'h0;
      r_err         <= w_resp_vld & w_resp.err;
      r_outstanding <= r_outstanding + CntW'(w_hs) - CntW'(r_rvalid);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MemWords); i++) r_mem[i] <= '0;
    end else if (w_hs & data_we_i & ~w_err) begin
      for (int b = 0; b < 4; b++)
        if (data_be_i[b]) r_mem[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
    end
  end

  assign data_gnt_o    = w_gnt;
  assign data_rvalid_o = r_rvalid;
  assign data_rdata_o  = r_rdata;
  assign data_err_o    = r_err;
  assign outstanding_o = r_outstanding;

  a_gnt_req: assert property (@(posedge clk_i) disable iff (!rst_ni) data_gnt_o |-> data_req_i);
  a_rv_out:  assert property (@(posedge clk_i) disable iff (!rst_ni) data_rvalid_o |-> (outstanding_o != '0));
  a_no_ovf:  assert property (@(posedge clk_i) disable iff (!rst_ni) w_push |-> w_fifo_in_rdy);
  a_params:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                              (RespLatency >= 1) && (MaxOutstanding >= 1) && (MemWords >= 4) &&
                              ((MemWords & (MemWords - 1)) == 0));
endmodule

// File: tb/tb_obi_data_mem_responder.sv
// Bench for obi_data_mem_responder: two instances (latency 1 and 3) checked by a scoreboard model
// plus table-driven transactions and hand-written timing/reset sequences.
module tb_obi_data_mem_responder;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req[2], we[2], stall[2], gnt[2], rvalid[2], err[2];
  logic [3:0]  be[2];
  logic [31:0] addr[2], wdata[2], rdata[2];
  logic [1:0]  outst[2];

  always #5 clk = ~clk;

  obi_data_mem_responder #(.AddrBase(32'h0), .MemWords(256), .MaxOutstanding(2), .RespLatency(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[0]), .data_gnt_o(gnt[0]), .data_we_i(we[0]),
    .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]), .data_rvalid_o(rvalid[0]),
    .data_rdata_o(rdata[0]), .data_err_o(err[0]), .gnt_stall_i(stall[0]), .outstanding_o(outst[0]));

  obi_data_mem_responder #(.AddrBase(32'h1000), .MemWords(16), .MaxOutstanding(2), .RespLatency(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[1]), .data_gnt_o(gnt[1]), .data_we_i(we[1]),
    .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]), .data_rvalid_o(rvalid[1]),
    .data_rdata_o(rdata[1]), .data_err_o(err[1]), .gnt_stall_i(stall[1]), .outstanding_o(outst[1]));

  function automatic int lat_of(int d);     return (d == 0) ? 1 : 3;       endfunction
  function automatic longint base_of(int d); return (d == 0) ? 0 : 'h1000; endfunction
  function automatic int words_of(int d);   return (d == 0) ? 256 : 16;    endfunction

  typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;
  exp_t        sbq[2][$];
  logic [31:0] mem_m[2][256];
  int          out_m[2];
  int          last_rv[2];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", nm, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: predicts grant, outstanding count and every response from the handshakes seen.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic   exp_gnt, exp_rv, hs, e_err;
      longint la, lb;
      int     idx, t;
      exp_t   e;
      if (!rst_n) begin
        chk($sformatf("rst_gnt%0d", d), gnt[d], 0);
        chk($sformatf("rst_rvalid%0d", d), rvalid[d], 0);
        chk($sformatf("rst_rdata%0d", d), rdata[d], 0);
        chk($sformatf("rst_err%0d", d), err[d], 0);
        chk($sformatf("rst_outstanding%0d", d), outst[d], 0);
        sbq[d].delete();
        out_m[d]   = 0;
        last_rv[d] = -1000;
        for (int i = 0; i < 256; i++) mem_m[d][i] = 32'h0;
      end else begin
        exp_gnt = req[d] & ~stall[d] & (out_m[d] < MAXO);
        chk($sformatf("gnt%0d", d), gnt[d], exp_gnt);
        chk($sformatf("outstanding%0d", d), outst[d], out_m[d]);
        exp_rv = (sbq[d].size() > 0) && (sbq[d][0].cyc == cyc);
        chk($sformatf("rvalid%0d", d), rvalid[d], exp_rv);
        if (exp_rv) begin
          e = sbq[d].pop_front();
          chk($sformatf("rdata%0d", d), rdata[d], e.rdata);
          chk($sformatf("err%0d", d), err[d], e.err);
        end else begin
          chk($sformatf("idle_rdata%0d", d), rdata[d], 0);
          chk($sformatf("idle_err%0d", d), err[d], 0);
        end
        hs = exp_gnt & req[d];
        if (hs) begin
          la    = longint'(addr[d]);
          lb    = base_of(d);
          e_err = (la < lb) || (la >= lb + 4 * words_of(d)) || (addr[d][1:0] != 2'b00);
          idx   = e_err ? 0 : int'((la - lb) >> 2);
          e.rdata = (e_err || we[d]) ? 32'h0 : mem_m[d][idx];
          e.err   = e_err;
          t = cyc + lat_of(d);
          if (t < last_rv[d] + 1) t = last_rv[d] + 1;
          last_rv[d] = t;
          e.cyc = t;
          sbq[d].push_back(e);
          if (!e_err && we[d])
            for (int b = 0; b < 4; b++)
              if (be[d][b]) mem_m[d][idx][8*b +: 8] = wdata[d][8*b +: 8];
        end
        out_m[d] = out_m[d] + int'(hs) - int'(exp_rv);
      end
    end
  end

  task automatic do_txn(input int d, input logic t_we, input logic [3:0] t_be, input logic [31:0] t_addr,
                        input logic [31:0] t_wd, output logic [31:0] rd, output logic er);
    bit got;
    rd = 32'h0;
    er = 1'b0;
    @(posedge clk); #1;
    req[d] = 1'b1; we[d] = t_we; be[d] = t_be; addr[d] = t_addr; wdata[d] = t_wd;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (gnt[d]) got = 1;
    end
    if (!got) timeout("txn_grant");
    @(posedge clk); #1;
    req[d] = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rvalid[d]) begin
        got = 1;
        rd  = rdata[d];
        er  = err[d];
      end
    end
    if (!got) timeout("txn_rvalid");
  endtask

  typedef struct {
    int d; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] exp_rd; logic exp_err; string nm;
  } vec_t;
  vec_t vt[16];

  initial begin
    logic [31:0] rd;
    logic        er, g;
    logic [5:0]  gpat;
    logic [8:0]  rpat;
    int          ng;

    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; stall[d] = 0; be[d] = 4'hF; addr[d] = 0; wdata[d] = 0;
    end
    rst_n = 1'b0;
    vt[0]  = '{0, 1, 4'b0101, 32'h0000_0010, 32'hAABB_CCDD, 32'h0,         0, "wr_be"};
    vt[1]  = '{0, 0, 4'b0000, 32'h0000_0010, 32'h0,         32'h00BB_00DD, 0, "rd_be"};
    vt[2]  = '{0, 0, 4'b1111, 32'h0000_0400, 32'h0,         32'h0,         1, "rd_oob"};
    vt[3]  = '{0, 1, 4'b1111, 32'h0000_0000, 32'h1122_3344, 32'h0,         0, "wr_w0"};
    vt[4]  = '{0, 1, 4'b1111, 32'h0000_0402, 32'hFFFF_FFFF, 32'h0,         1, "wr_bad"};
    vt[5]  = '{0, 0, 4'b1111, 32'h0000_0000, 32'h0,         32'h1122_3344, 0, "rd_w0_kept"};
    vt[6]  = '{0, 0, 4'b1111, 32'h0000_03FC, 32'h0,         32'h0,         0, "rd_last"};
    vt[7]  = '{0, 1, 4'b1010, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,         0, "wr_last"};
    vt[8]  = '{0, 0, 4'b0001, 32'h0000_03FC, 32'h0,         32'hCA00_F000, 0, "rd_last_be"};
    vt[9]  = '{0, 0, 4'b1111, 32'h0000_0013, 32'h0,         32'h0,         1, "rd_misal"};
    vt[10] = '{1, 0, 4'b1111, 32'h0000_0FFC, 32'h0,         32'h0,         1, "rd_below"};
    vt[11] = '{1, 1, 4'b1111, 32'h0000_103C, 32'h1234_5678, 32'h0,         0, "wr_top1"};
    vt[12] = '{1, 0, 4'b1111, 32'h0000_103C, 32'h0,         32'h1234_5678, 0, "rd_top1"};
    vt[13] = '{1, 0, 4'b1111, 32'h0000_1040, 32'h0,         32'h0,         1, "rd_above1"};
    vt[14] = '{1, 1, 4'b1111, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0,         0, "wr_w1"};
    vt[15] = '{1, 0, 4'b1111, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 0, "rd_w1"};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single read right after reset on the latency-1 instance.
    req[0] = 1; we[0] = 0; addr[0] = 32'h0;
    @(negedge clk);
    chk("t1_gnt", gnt[0], 1);
    chk("t1_out_c0", outst[0], 0);
    @(posedge clk); #1;
    req[0] = 0;
    @(negedge clk);
    chk("t1_rvalid_c1", rvalid[0], 1);
    chk("t1_rdata", rdata[0], 0);
    chk("t1_err", err[0], 0);
    chk("t1_out_c1", outst[0], 1);
    @(negedge clk);
    chk("t1_rvalid_c2", rvalid[0], 0);
    chk("t1_out_c2", outst[0], 0);

    for (int i = 0; i < 16; i++) begin
      do_txn(vt[i].d, vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata, rd, er);
      chk({vt[i].nm, "_rdata"}, rd, vt[i].exp_rd);
      chk({vt[i].nm, "_err"}, er, vt[i].exp_err);
    end

    // Back-to-back reads against a 2-deep, latency-3 responder.
    @(posedge clk); #1;
    req[1] = 1; we[1] = 0; addr[1] = 32'h1000;
    ng = 0; gpat = '0; rpat = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 6) gpat[c] = gnt[1];
      rpat[c] = rvalid[1];
      g = gnt[1];
      @(posedge clk); #1;
      if (g && req[1]) begin
        ng++;
        addr[1] = 32'h1000 + 32'(4 * ng);
        if (ng == 4) req[1] = 0;
      end
    end
    req[1] = 0;
    chk("b2b_gnt_pattern", gpat, 6'b110011);
    chk("b2b_rvalid_pattern", rpat, 9'b110011000);
    chk("b2b_grants", ng, 4);

    // No request: nothing may be granted or answered whatever the stall input does.
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      stall[0] = 1'($urandom_range(0, 1));
      stall[1] = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_gnt0", gnt[0], 0);
      chk("idle_gnt1", gnt[1], 0);
      chk("idle_rv0", rvalid[0], 0);
      chk("idle_rv1", rvalid[1], 0);
    end
    @(posedge clk); #1;
    stall[0] = 1; stall[1] = 1; req[0] = 1; req[1] = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_gnt0", gnt[0], 0);
      chk("stall_gnt1", gnt[1], 0);
      chk("stall_rv0", rvalid[0], 0);
      chk("stall_rv1", rvalid[1], 0);
    end
    @(posedge clk); #1;
    req[0] = 0; req[1] = 0; stall[0] = 0; stall[1] = 0;

    // Reset while two reads are in flight: their responses must never appear.
    @(posedge clk); #1;
    req[1] = 1; we[1] = 0; addr[1] = 32'h1004;
    ng = 0;
    for (int c = 0; c < 10 && ng < 2; c++) begin
      @(negedge clk);
      g = gnt[1];
      @(posedge clk); #1;
      if (g) begin
        ng++;
        addr[1] = 32'h1008;
      end
    end
    req[1] = 0;
    chk("rst_grants", ng, 2);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_rst_rv1", rvalid[1], 0);
      chk("post_rst_out1", outst[1], 0);
    end
    do_txn(1, 0, 4'hF, 32'h1004, 32'h0, rd, er);
    chk("post_rst_mem1", rd, 32'h0);
    do_txn(0, 0, 4'hF, 32'h0, 32'h0, rd, er);
    chk("post_rst_mem0", rd, 32'h0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("sb_empty0", sbq[0].size(), 0);
    chk("sb_empty1", sbq[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
